// File: rtl/tcdm_arb_pkg.sv
// Shared types and constants for the TCDM round-robin arbiter.
// id_t is sized for the largest supported requester count so every block agrees on its width.
package tcdm_arb_pkg;
  localparam int NB_IN_MAX = 16;
  localparam int ID_W      = $clog2(NB_IN_MAX);
  localparam int CNT_W     = 32;

  typedef logic [ID_W-1:0] id_t;

  // Round-robin successor of index w among nb requesters.
  function automatic id_t rr_next(id_t w, int nb);
    return (int'(w) == nb - 1) ? '0 : w + 1'b1;
  endfunction
endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Requester-side and memory-side bus of the TCDM arbiter in one bundle.
// Handshake: a request is accepted on a cycle where out_req_o & out_gnt_i; each accepted request
// gets exactly one out_r_valid_i, in order, at least one cycle later (reads and writes alike).
interface tcdm_rr_arbiter_if #(
  parameter int NB_IN = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int BW = DW / 8;

  logic [NB_IN-1:0]          in_req_i;
  logic [NB_IN-1:0]          in_gnt_o;
  logic [NB_IN-1:0][AW-1:0]  in_add_i;
  logic [NB_IN-1:0]          in_wen_i;
  logic [NB_IN-1:0][BW-1:0]  in_be_i;
  logic [NB_IN-1:0][DW-1:0]  in_data_i;
  logic [NB_IN-1:0][DW-1:0]  in_r_data_o;
  logic [NB_IN-1:0]          in_r_valid_o;

  logic                      out_req_o;
  logic                      out_gnt_i;
  logic [AW-1:0]             out_add_o;
  logic                      out_wen_o;
  logic [BW-1:0]             out_be_o;
  logic [DW-1:0]             out_data_o;
  logic [DW-1:0]             out_r_data_i;
  logic                      out_r_valid_i;

  // Arbiter view.
  modport slave (
    input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    input  out_gnt_i, out_r_data_i, out_r_valid_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o
  );

  // Environment view: requesters plus memory.
  modport master (
    output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    output out_gnt_i, out_r_data_i, out_r_valid_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o
  );
endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of requester IDs awaiting a memory response; flop storage, no fall-through.
// A push is refused whenever the FIFO is full, even if a pop happens in the same cycle.
module tcdm_arb_id_fifo
  import tcdm_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic push_i,
  input  logic pop_i,
  input  id_t  data_i,
  output id_t  data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  id_t           mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && !clear_i && wptr_q == PW'(i)) mem_q[i] <= data_i;
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rptr_q == PW'(i)) data_o = mem_q[i];
    end
  end
endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin N:1 TCDM arbiter with in-order response routing through an ID FIFO.
// Define TCDM_ARB_PERF_CNT_EN to build the saturating grant/stall counters; otherwise they read 0.
module tcdm_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int NB_IN    = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ID_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  tcdm_rr_arbiter_if.slave bus,
  output logic             err_o,
  output logic [CNT_W-1:0] cnt_gnt_o,
  output logic [CNT_W-1:0] cnt_stall_o
);
  id_t  rr_q, winner, head;
  logic found, any_req, hs, pop, fifo_full, fifo_empty, err_q;

  // Search upward from rr_q first, then wrap to the lowest requesting index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NB_IN; j++) begin
      if (!found && bus.in_req_i[j] && id_t'(j) >= rr_q) begin
        winner = id_t'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NB_IN; j++) begin
      if (!found && bus.in_req_i[j]) begin
        winner = id_t'(j);
        found  = 1'b1;
      end
    end
  end

  // Reset gating matters: an empty FIFO does not suppress requests on its own.
  assign any_req       = |bus.in_req_i;
  assign bus.out_req_o = rst_ni & any_req & ~fifo_full;
  assign hs            = bus.out_req_o & bus.out_gnt_i;
  assign pop           = bus.out_r_valid_i & ~fifo_empty;

  always_comb begin
    bus.out_add_o  = '0;
    bus.out_wen_o  = 1'b0;
    bus.out_be_o   = '0;
    bus.out_data_o = '0;
    bus.in_gnt_o   = '0;
    if (bus.out_req_o) begin
      for (int j = 0; j < NB_IN; j++) begin
        if (winner == id_t'(j)) begin
          bus.out_add_o  = bus.in_add_i[j];
          bus.out_wen_o  = bus.in_wen_i[j];
          bus.out_be_o   = bus.in_be_i[j];
          bus.out_data_o = bus.in_data_i[j];
          bus.in_gnt_o[j] = bus.out_gnt_i;
        end
      end
    end
  end

  always_comb begin
    bus.in_r_valid_o = '0;
    bus.in_r_data_o  = '0;
    if (pop) begin
      for (int j = 0; j < NB_IN; j++) begin
        if (head == id_t'(j)) begin
          bus.in_r_valid_o[j] = 1'b1;
          bus.in_r_data_o[j]  = bus.out_r_data_i;
        end
      end
    end
  end

  tcdm_arb_id_fifo #(
    .DEPTH (ID_DEPTH)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (hs),
    .pop_i   (pop),
    .data_i  (winner),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs) rr_q <= rr_next(winner, NB_IN);
      if (bus.out_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

`ifdef TCDM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_gnt_q, cnt_stall_q;
  logic             stall;

  assign stall = any_req & ~|bus.in_gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_gnt_q   <= '0;
      cnt_stall_q <= '0;
    end else if (clear_i) begin
      cnt_gnt_q   <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (hs && cnt_gnt_q != '1)      cnt_gnt_q   <= cnt_gnt_q + 1'b1;
      if (stall && cnt_stall_q != '1) cnt_stall_q <= cnt_stall_q + 1'b1;
    end
  end

  assign cnt_gnt_o   = cnt_gnt_q;
  assign cnt_stall_o = cnt_stall_q;
`else
  assign cnt_gnt_o   = '0;
  assign cnt_stall_o = '0;
`endif
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter: the bench plays requesters and memory cycle by cycle.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
module tb_tcdm_rr_arbiter;
  localparam int NB_IN = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef TCDM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        err_o;
  logic [31:0] cnt_gnt_o, cnt_stall_o;

  int errors = 0;
  int checks = 0;

  logic [NB_IN-1:0][DW-1:0] exp_rd;
  logic [31:0]              exp_cnt;

  tcdm_rr_arbiter_if #(.NB_IN(NB_IN), .AW(AW), .DW(DW)) bus ();

  tcdm_rr_arbiter #(
    .NB_IN    (NB_IN),
    .AW       (AW),
    .DW       (DW),
    .ID_DEPTH (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .bus         (bus.slave),
    .err_o       (err_o),
    .cnt_gnt_o   (cnt_gnt_o),
    .cnt_stall_o (cnt_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    bus.in_req_i      = '0;
    bus.out_gnt_i     = 1'b0;
    bus.out_r_valid_i = 1'b0;
    bus.out_r_data_i  = '0;
    clear_i           = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    idle();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle();
    bus.in_req_i  = 4'hF;
    bus.out_gnt_i = 1'b1;
    bus.in_add_i  = '{32'h4, 32'h3, 32'h2, 32'h1};
    bus.in_wen_i  = 4'hF;
    bus.in_be_i   = '{4'hF, 4'hF, 4'hF, 4'hF};
    bus.in_data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    checks++; if (bus.out_req_o !== 1'b0) begin errors++; $display("FAIL reset_out_req: got %b want 0", bus.out_req_o); end
    checks++; if (bus.in_gnt_o !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.in_gnt_o); end
    checks++; if (bus.out_add_o !== 32'h0) begin errors++; $display("FAIL reset_out_add: got %h want 0", bus.out_add_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (cnt_gnt_o !== 32'h0 || cnt_stall_o !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_gnt_o, cnt_stall_o); end
    idle();
    rst_ni = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NB_IN; i++) bus.in_add_i[i] = 32'h1000 + 32'(i * 4);
    bus.in_wen_i = 4'hF;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk_i);
      bus.in_req_i      = (c < 8) ? 4'hF : 4'h0;
      bus.out_gnt_i     = 1'b1;
      bus.out_r_valid_i = (c > 0);
      bus.out_r_data_i  = 32'hA000_0000 + 32'(c);
      #1;
      if (c < 8) begin
        checks++; if (bus.in_gnt_o !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus.in_gnt_o, 4'(1 << (c % 4))); end
        checks++; if (bus.out_add_o !== 32'h1000 + 32'((c % 4) * 4)) begin errors++; $display("FAIL rr_add c%0d: got %h", c, bus.out_add_o); end
      end
      if (c > 0) begin
        exp_rd = '0;
        exp_rd[(c - 1) % 4] = 32'hA000_0000 + 32'(c);
        checks++; if (bus.in_r_valid_o !== 4'(1 << ((c - 1) % 4))) begin errors++; $display("FAIL rr_rvalid c%0d: got %b want %b", c, bus.in_r_valid_o, 4'(1 << ((c - 1) % 4))); end
        checks++; if (bus.in_r_data_o !== exp_rd) begin errors++; $display("FAIL rr_rdata c%0d: got %h want %h", c, bus.in_r_data_o, exp_rd); end
      end
    end
    @(negedge clk_i);
    idle();
    #1;
    exp_cnt = PERF ? 32'd8 : 32'd0;
    checks++; if (cnt_gnt_o !== exp_cnt) begin errors++; $display("FAIL rr_cnt_gnt: got %0d want %0d", cnt_gnt_o, exp_cnt); end
    checks++; if (bus.in_r_valid_o !== 4'h0 || err_o !== 1'b0) begin errors++; $display("FAIL rr_idle: rvalid %b err %b want 0000 0", bus.in_r_valid_o, err_o); end
  endtask

  task automatic test_stall();
    do_clear();
    bus.in_add_i[1] = 32'h11;
    bus.in_add_i[3] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      bus.in_req_i  = 4'b1010;
      bus.out_gnt_i = 1'b0;
      #1;
      checks++; if (bus.out_req_o !== 1'b1 || bus.in_gnt_o !== 4'h0) begin errors++; $display("FAIL stall_hold k%0d: req %b gnt %b want 1 0000", k, bus.out_req_o, bus.in_gnt_o); end
      checks++; if (bus.out_add_o !== 32'h11) begin errors++; $display("FAIL stall_winner k%0d: got %h want 11", k, bus.out_add_o); end
    end
    @(negedge clk_i);
    bus.out_gnt_i = 1'b1;
    #1;
    exp_cnt = PERF ? 32'd3 : 32'd0;
    checks++; if (bus.in_gnt_o !== 4'b0010) begin errors++; $display("FAIL stall_first_gnt: got %b want 0010", bus.in_gnt_o); end
    checks++; if (cnt_stall_o !== exp_cnt) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", cnt_stall_o, exp_cnt); end
    @(negedge clk_i); #1;
    checks++; if (bus.in_gnt_o !== 4'b1000) begin errors++; $display("FAIL stall_second_gnt: got %b want 1000", bus.in_gnt_o); end
    @(negedge clk_i);
    idle();
    bus.out_r_valid_i = 1'b1;
    bus.out_r_data_i  = 32'h111;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'b0010 || bus.in_r_data_o[1] !== 32'h111) begin errors++; $display("FAIL stall_resp1: rvalid %b data %h want 0010 111", bus.in_r_valid_o, bus.in_r_data_o[1]); end
    @(negedge clk_i);
    bus.out_r_data_i = 32'h333;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'b1000 || bus.in_r_data_o[3] !== 32'h333) begin errors++; $display("FAIL stall_resp3: rvalid %b data %h want 1000 333", bus.in_r_valid_o, bus.in_r_data_o[3]); end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_fifo_full();
    logic       exp_req;
    logic [3:0] exp_rv;
    do_clear();
    bus.in_add_i[0] = 32'h200;
    bus.in_wen_i    = 4'hF;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk_i);
      bus.in_req_i      = (c < 6) ? 4'b0001 : 4'b0000;
      bus.out_gnt_i     = 1'b1;
      bus.out_r_valid_i = (c >= 4);
      bus.out_r_data_i  = 32'h40 + 32'(c - 4);
      exp_req = (c < 2) || (c == 5);
      exp_rv  = (c >= 4) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (bus.out_req_o !== exp_req) begin errors++; $display("FAIL full_out_req c%0d: got %b want %b", c, bus.out_req_o, exp_req); end
      checks++; if (bus.in_r_valid_o !== exp_rv) begin errors++; $display("FAIL full_rvalid c%0d: got %b want %b", c, bus.in_r_valid_o, exp_rv); end
      if (c == 2) begin
        checks++; if (bus.out_add_o !== 32'h0 || bus.out_wen_o !== 1'b0) begin errors++; $display("FAIL full_out_zero: add %h wen %b want 0 0", bus.out_add_o, bus.out_wen_o); end
      end
    end
    @(negedge clk_i);
    idle();
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err_o); end
  endtask

  task automatic test_write_read();
    @(negedge clk_i);
    bus.in_req_i     = 4'b0100;
    bus.in_wen_i     = 4'b1011;
    bus.in_add_i[2]  = 32'h100;
    bus.in_data_i[2] = 32'hDEADBEEF;
    bus.in_be_i[2]   = 4'hF;
    bus.in_add_i[0]  = 32'h100;
    bus.in_data_i[0] = 32'h0;
    bus.out_gnt_i    = 1'b1;
    #1;
    checks++; if (bus.in_gnt_o !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b want 0100", bus.in_gnt_o); end
    checks++; if (bus.out_wen_o !== 1'b0 || bus.out_add_o !== 32'h100 || bus.out_data_o !== 32'hDEADBEEF || bus.out_be_o !== 4'hF) begin errors++; $display("FAIL wr_bus: wen %b add %h data %h be %h", bus.out_wen_o, bus.out_add_o, bus.out_data_o, bus.out_be_o); end
    @(negedge clk_i);
    bus.in_req_i      = 4'b0001;
    bus.out_r_valid_i = 1'b1;
    bus.out_r_data_i  = 32'h0;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'b0100) begin errors++; $display("FAIL wr_resp: got %b want 0100", bus.in_r_valid_o); end
    checks++; if (bus.in_gnt_o !== 4'b0001 || bus.out_wen_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: gnt %b wen %b want 0001 1", bus.in_gnt_o, bus.out_wen_o); end
    @(negedge clk_i);
    bus.in_req_i     = 4'b0000;
    bus.out_r_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'b0001 || bus.in_r_data_o[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp: rvalid %b data %h want 0001 deadbeef", bus.in_r_valid_o, bus.in_r_data_o[0]); end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_spurious();
    @(negedge clk_i);
    idle();
    bus.out_r_valid_i = 1'b1;
    bus.out_r_data_i  = 32'h55;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'h0 || bus.in_r_data_o !== '0) begin errors++; $display("FAIL spur_rvalid: got %b want 0000", bus.in_r_valid_o); end
    @(negedge clk_i);
    idle();
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b want 1", err_o); end
    @(negedge clk_i);
    clear_i = 1'b1;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b want 1", err_o); end
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b want 0", err_o); end
  endtask

  task automatic test_reset_mid();
    bus.in_wen_i = 4'hF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      bus.in_req_i  = 4'b0011;
      bus.out_gnt_i = 1'b1;
      #1;
      checks++; if (bus.in_gnt_o !== 4'(1 << c)) begin errors++; $display("FAIL rmid_gnt c%0d: got %b want %b", c, bus.in_gnt_o, 4'(1 << c)); end
    end
    @(negedge clk_i);
    rst_ni            = 1'b0;
    bus.out_r_valid_i = 1'b1;
    bus.out_r_data_i  = 32'h77;
    #1;
    checks++; if (bus.out_req_o !== 1'b0 || bus.in_gnt_o !== 4'h0 || bus.out_add_o !== 32'h0) begin errors++; $display("FAIL rmid_req: req %b gnt %b add %h want 0", bus.out_req_o, bus.in_gnt_o, bus.out_add_o); end
    checks++; if (bus.in_r_valid_o !== 4'h0 || bus.in_r_data_o !== '0) begin errors++; $display("FAIL rmid_rvalid: got %b want 0000", bus.in_r_valid_o); end
    checks++; if (err_o !== 1'b0 || cnt_gnt_o !== 32'h0 || cnt_stall_o !== 32'h0) begin errors++; $display("FAIL rmid_state: err %b cnt %0d/%0d want 0", err_o, cnt_gnt_o, cnt_stall_o); end
    @(negedge clk_i);
    idle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus.out_r_valid_i = 1'b1;
    bus.out_r_data_i  = 32'h78;
    #1;
    checks++; if (bus.in_r_valid_o !== 4'h0) begin errors++; $display("FAIL rmid_drop: got %b want 0000", bus.in_r_valid_o); end
    @(negedge clk_i);
    idle();
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rmid_err: got %b want 1", err_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_write_read();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tcdm_rr_arbiter.md
TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

Interface
REQ-001 SHALL have parameter NB_IN, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width; BE width is DW/8.
REQ-004 SHALL have parameter ID_DEPTH, default 2: depth of the outstanding-ID FIFO, at least 1.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 SHALL have port clear_i  in  1  synchronous clear.
REQ-007 SHALL have requester-side ports: in_req_i  in  NB_IN; in_gnt_o  out  NB_IN; in_add_i  in  NB_IN x AW; in_wen_i  in  NB_IN (1 = read); in_be_i  in  NB_IN x DW/8; in_data_i  in  NB_IN x DW; in_r_data_o  out  NB_IN x DW; in_r_valid_o  out  NB_IN.
REQ-008 SHALL have memory-side ports: out_req_o  out  1; out_gnt_i  in  1; out_add_o  out  AW; out_wen_o  out  1; out_be_o  out  DW/8; out_data_o  out  DW; out_r_data_i  in  DW; out_r_valid_i  in  1.
REQ-009 SHALL have port err_o  out  1: sticky protocol error.
REQ-010 SHALL have ports cnt_gnt_o  out  32 and cnt_stall_o  out  32: performance counters.

Function
REQ-011 SHALL assert out_req_o combinationally when any in_req_i bit is high and the ID FIFO is not full.
REQ-012 SHALL select the winner as the first index with in_req_i high, searching upward from rr_q and wrapping modulo NB_IN.
REQ-013 SHALL drive the winner's add/wen/be/data onto out_*; when out_req_o is low, out_* SHALL be 0.
REQ-014 SHALL set in_gnt_o[w] = out_gnt_i & out_req_o for the winner w only; all other in_gnt_o bits SHALL be 0.
REQ-015 SHALL, on a handshake (out_req_o & out_gnt_i), update rr_q to (w+1) mod NB_IN and push w into the ID FIFO.
REQ-016 SHALL hold rr_q unchanged when no handshake occurs, including while out_gnt_i is low, so the winner is stable during memory stalls.
REQ-017 SHALL expect one out_r_valid_i per handshake, for both reads and writes, returned in order, at latency of 1 cycle or more.
REQ-018 SHALL, on out_r_valid_i, pop the FIFO head h, assert in_r_valid_o[h] and drive in_r_data_o[h] = out_r_data_i in the same cycle; all other r_valid bits SHALL be 0 and all other r_data lanes SHALL be 0.
REQ-019 SHALL block pushes whenever the FIFO count equals ID_DEPTH, even if a pop occurs in the same cycle (no fall-through).
REQ-020 SHALL allow a simultaneous push and pop when not full, leaving the count unchanged.
REQ-021 SHALL, when out_r_valid_i arrives with the FIFO empty, drop the response, assert no in_r_valid_o, and set err_o, which stays set until reset or clear_i.
REQ-022 SHALL, on clear_i, set rr_q to 0, empty the FIFO, clear err_o and zero the counters on the next edge; a handshake in that same cycle SHALL NOT be recorded.
REQ-023 SHALL treat a requester dropping req before its grant as legal; it simply loses arbitration and no FIFO entry is created.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously set rr_q to 0, FIFO count and pointers to 0, err_o to 0 and the counters to 0.
REQ-025 SHALL, during reset, hold all outputs at 0, including out_req_o, because the FIFO empty state does not gate requests.
REQ-026 SHALL discard outstanding responses when reset is asserted mid-transaction; the first r_valid after reset SHALL set err_o.

Configuration
REQ-027 SHALL, when macro TCDM_ARB_PERF_CNT_EN is defined, saturate-increment cnt_gnt_o on each handshake and cnt_stall_o on each cycle where any in_req_i bit is high but no in_gnt_o bit is high.
REQ-028 SHALL, when TCDM_ARB_PERF_CNT_EN is undefined, tie cnt_gnt_o and cnt_stall_o to 0 and instantiate no counter flops.

Structure
REQ-029 SHALL place the following in shared package tcdm_arb_pkg: the ID index type (clog2 of NB_IN_MAX = 16) and the constant CNT_W = 32.
REQ-030 SHALL implement the ID FIFO as sub-module tcdm_arb_id_fifo, with push/pop/full/empty and flop-based storage of depth ID_DEPTH.

Verification
REQ-031 All 4 requesters reading continuously, out_gnt_i = 1, 1-cycle latency -> grants in order 0,1,2,3,0,...; each in_r_valid_o is routed to the correct index; cnt_gnt_o = 8 after 8 cycles.
REQ-032 Requesters 1 and 3 active, out_gnt_i low for 3 cycles -> in_gnt_o = 0 and rr_q held; when out_gnt_i rises, requester 1 is granted first and cnt_stall_o = 3.
REQ-033 ID_DEPTH = 2 with response latency 4 -> after 2 handshakes out_req_o = 0 until the first r_valid, and no push occurs in the pop cycle.
REQ-034 Requester 2 writes 0xDEADBEEF to 0x100, then requester 0 reads 0x100 -> in_r_valid_o[2] fires first, then in_r_data_o[0] = 0xDEADBEEF.
REQ-035 Spurious out_r_valid_i with the FIFO empty -> err_o = 1 and no in_r_valid_o; a subsequent clear_i returns err_o to 0.
REQ-036 rst_ni asserted with 2 transactions outstanding -> all outputs 0 immediately; after release, the first r_valid sets err_o.
